// File: rtl/snn_pkg.sv
// Shared SNN types, defaults and helpers.
// Used by the spike rate decoder and the neuron core.
package snn_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } dec_state_t;

   localparam int DEFAULT_WINDOW_LEN = 256;

   function automatic logic [31:0] sat_inc(
      input logic [31:0] v,
      input logic [31:0] max_v
   );
      return (v >= max_v) ? max_v : v + 32'd1;
   endfunction

endpackage

// File: rtl/spike_isi_timer.sv
// Inter-spike interval timer: cycles since last spike, latched on each spike.
// isi already reflects a spike arriving in the current cycle.
module spike_isi_timer
   import snn_pkg::*;
#(
   parameter int ISI_WIDTH = 12
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 spike_in,
   output logic [ISI_WIDTH-1:0] isi,
   output logic                 isi_seen
);

   localparam logic [ISI_WIDTH-1:0] ISI_MAX = '1;

   logic [ISI_WIDTH-1:0] timer_q;
   logic [ISI_WIDTH-1:0] last_q;
   logic                 seen_q;
   logic [ISI_WIDTH-1:0] timer_inc;

   assign timer_inc = ISI_WIDTH'(sat_inc(32'(timer_q), 32'(ISI_MAX)));
   assign isi       = (spike_in && seen_q) ? timer_inc : last_q;
   assign isi_seen  = seen_q || spike_in;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         timer_q <= '0;
         last_q  <= '0;
         seen_q  <= 1'b0;
      end else if (spike_in) begin
         if (seen_q) last_q <= timer_inc;
         timer_q <= '0;
         seen_q  <= 1'b1;
      end else begin
         timer_q <= timer_inc;
      end
   end

endmodule

// File: rtl/spike_rate_decoder.sv
// Spike-train to rate decoder: per-window spike count and ISI over valid/ready.
// Define ISI_MEASURE_EN to build the ISI timer; otherwise isi_out is tied to 0.
module spike_rate_decoder
   import snn_pkg::*;
#(
   parameter int WINDOW_LEN = DEFAULT_WINDOW_LEN,
   parameter int CNT_WIDTH  = 9,
   parameter int ISI_WIDTH  = 12
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic                 spike_in,
   input  logic                 out_ready,
   output logic                 out_valid,
   output logic [CNT_WIDTH-1:0] rate_out,
   output logic [ISI_WIDTH-1:0] isi_out,
   output logic                 overrun
);

   localparam int WW = $clog2(WINDOW_LEN);
   localparam logic [WW-1:0]        WIN_LAST = WW'(WINDOW_LEN - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

   dec_state_t           state_q, state_d;
   logic [WW-1:0]        win_q, win_d;
   logic [CNT_WIDTH-1:0] spk_q, spk_d;
   logic                 valid_q, valid_d;
   logic [CNT_WIDTH-1:0] rate_q, rate_d;
   logic [ISI_WIDTH-1:0] isi_q, isi_d;
   logic                 ovr_q, ovr_d;

   logic                 counting;
   logic                 close;
   logic                 xfer;
   logic [CNT_WIDTH-1:0] spk_now;
   logic [ISI_WIDTH-1:0] isi_val;

   assign counting = (state_q == COUNT) && enable;
   assign close    = counting && (win_q == WIN_LAST);
   assign xfer     = valid_q && out_ready;
   assign spk_now  = spike_in
                   ? CNT_WIDTH'(sat_inc(32'(spk_q), 32'(CNT_MAX)))
                   : spk_q;

`ifdef ISI_MEASURE_EN
   logic [ISI_WIDTH-1:0] isi_raw;
   logic                 isi_seen;

   // Tracking is held cleared whenever no window is being counted.
   spike_isi_timer #(
      .ISI_WIDTH (ISI_WIDTH)
   ) u_isi (
      .clk      (clk),
      .rst      (rst),
      .clr      (!counting),
      .spike_in (spike_in && counting),
      .isi      (isi_raw),
      .isi_seen (isi_seen)
   );

   assign isi_val = isi_seen ? isi_raw : '0;
`else
   assign isi_val = '0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         win_q   <= '0;
         spk_q   <= '0;
         valid_q <= 1'b0;
         rate_q  <= '0;
         isi_q   <= '0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         spk_q   <= spk_d;
         valid_q <= valid_d;
         rate_q  <= rate_d;
         isi_q   <= isi_d;
         ovr_q   <= ovr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      spk_d   = spk_q;
      valid_d = valid_q;
      rate_d  = rate_q;
      isi_d   = isi_q;
      ovr_d   = ovr_q;

      unique case (state_q)
         IDLE: begin
            if (enable) begin
               state_d = COUNT;
               win_d   = '0;
               spk_d   = '0;
            end
         end
         COUNT: begin
            if (!enable) begin
               state_d = IDLE;
            end else if (close) begin
               win_d = '0;
               spk_d = '0;
            end else begin
               win_d = win_q + WW'(1);
               spk_d = spk_now;
            end
         end
      endcase

      if (xfer) valid_d = 1'b0;

      // A full, unaccepted output wins over the new result.
      if (close) begin
         if (!valid_q || out_ready) begin
            valid_d = 1'b1;
            rate_d  = spk_now;
            isi_d   = isi_val;
         end else begin
            ovr_d = 1'b1;
         end
      end
   end

   assign out_valid = valid_q;
   assign rate_out  = rate_q;
   assign isi_out   = isi_q;
   assign overrun   = ovr_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Self-checking bench for spike_rate_decoder (WINDOW_LEN=16).
// Event-level reference model plus hand-computed window results.
module tb_spike_rate_decoder;

   localparam int WL = 16;
   localparam int CW = 9;
   localparam int IW = 12;
   localparam int CNT_SAT = (1 << CW) - 1;
   localparam int ISI_SAT = (1 << IW) - 1;
`ifdef ISI_MEASURE_EN
   localparam bit ISI_ON = 1'b1;
`else
   localparam bit ISI_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          enable;
   logic          spike_in;
   logic          out_ready;
   logic          out_valid;
   logic [CW-1:0] rate_out;
   logic [IW-1:0] isi_out;
   logic          overrun;

   spike_rate_decoder #(
      .WINDOW_LEN (WL),
      .CNT_WIDTH  (CW),
      .ISI_WIDTH  (IW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .spike_in  (spike_in),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .rate_out  (rate_out),
      .isi_out   (isi_out),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference model: window position, spike count, absolute spike times.
   bit m_active;
   int m_pos, m_cnt, m_nsp, m_tlast, m_isi, cyc;
   bit e_valid, e_ovr;
   int e_rate, e_isi;

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic void model_step();
      bit xfer;
      bit close;
      cyc++;
      close = 1'b0;
      if (rst) begin
         m_active = 0; m_pos = 0; m_cnt = 0;
         m_nsp = 0; m_isi = 0; m_tlast = 0;
         e_valid = 0; e_rate = 0; e_isi = 0; e_ovr = 0;
         return;
      end
      xfer = e_valid && out_ready;
      if (!m_active) begin
         if (enable) begin
            m_active = 1; m_pos = 0; m_cnt = 0;
         end
      end else if (!enable) begin
         m_active = 0; m_nsp = 0; m_isi = 0;
      end else begin
         if (spike_in) begin
            m_cnt = imin(m_cnt + 1, CNT_SAT);
            if (m_nsp > 0) m_isi = imin(cyc - m_tlast, ISI_SAT);
            m_tlast = cyc;
            m_nsp++;
         end
         close = (m_pos == WL - 1);
         m_pos = close ? 0 : m_pos + 1;
      end
      if (xfer) e_valid = 0;
      if (close) begin
         if (!e_valid) begin
            e_valid = 1;
            e_rate  = m_cnt;
            e_isi   = ISI_ON ? m_isi : 0;
         end else begin
            e_ovr = 1;
         end
         m_cnt = 0;
      end
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         check("out_valid", 32'(out_valid), 32'(e_valid));
         check("overrun", 32'(overrun), 32'(e_ovr));
         if (e_valid) begin
            check("rate_out", 32'(rate_out), 32'(e_rate));
            check("isi_out", 32'(isi_out), 32'(e_isi));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         model_step();
         #1;
      end
   endtask

   task automatic run_window(input logic [15:0] pat, input bit drop_ready);
      for (int i = 0; i < WL; i++) begin
         spike_in = pat[i];
         if (drop_ready && i == 1) out_ready = 1'b0;
         tick(1);
      end
   endtask

   task automatic lit(input string tag, input int r, input int isi);
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_rate"}, 32'(rate_out), 32'(r));
      check({tag, "_isi"}, 32'(isi_out), ISI_ON ? 32'(isi) : 32'd0);
   endtask

   int lat;

   initial begin
      rst = 1'b1; enable = 1'b1; spike_in = 1'b1; out_ready = 1'b1;
      tick(1);
      chk_en = 1'b1;
      tick(2);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_rate", 32'(rate_out), 32'd0);
      check("rst_isi", 32'(isi_out), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);

      rst = 1'b0; enable = 1'b0; spike_in = 1'b0;
      tick(2);

      // every 4th cycle
      enable = 1'b1;
      tick(1);
      run_window(16'h1111, 1'b0);
      lit("every4_w1", 4, 4);
      run_window(16'h1111, 1'b0);
      lit("every4_w2", 4, 4);

      // continuous spikes, last cycle included
      run_window(16'hFFFF, 1'b0);
      lit("full", 16, 1);

      // back-pressure over two closes
      run_window(16'h0101, 1'b1);
      lit("bp_first", 2, 8);
      check("bp_ovr0", 32'(overrun), 32'd0);
      run_window(16'hFFFF, 1'b0);
      lit("bp_held", 2, 8);
      check("bp_ovr1", 32'(overrun), 32'd1);
      out_ready = 1'b1;
      run_window(16'h0003, 1'b0);
      lit("bp_after", 2, 1);
      check("bp_ovr_sticky", 32'(overrun), 32'd1);

      // abort at window cycle 9
      for (int i = 0; i < 9; i++) begin
         spike_in = (i % 2 == 0);
         tick(1);
      end
      enable = 1'b0; spike_in = 1'b1;
      tick(1);
      spike_in = 1'b0;
      tick(20);
      check("abort_valid", 32'(out_valid), 32'd0);
      check("abort_rate", 32'(rate_out), 32'd2);
      check("abort_isi", 32'(isi_out), ISI_ON ? 32'd1 : 32'd0);

      // restart: full window, latency from enable
      enable = 1'b1;
      tick(1);
      lat = 0;
      for (int i = 1; i <= 40; i++) begin
         spike_in = ((i - 1) % 4 == 0);
         tick(1);
         if (out_valid) begin
            lat = i;
            break;
         end
      end
      check("restart_latency", 32'(lat), 32'd16);
      lit("restart", 4, 4);

      // lone spike in the closing cycle; ISI spans the boundary
      run_window(16'h8000, 1'b0);
      lit("last_only", 1, 19);

      spike_in = 1'b0;
      tick(3);
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
